light_arbiter: RTL and testbench
================================

LIGHT_ARBITER -- requirements
Module: light_arbiter

Interface
REQ-001 The block SHALL have parameter N_ROOMS, default 8, the number of rooms; this specification is written for 8.
REQ-002 The block SHALL have parameter MAX_ON, default 4, the maximum number of simultaneously lit rooms (range 1..N_ROOMS).
REQ-003 The block SHALL have parameter HOLD, default 9, the 4-bit countdown reload value (range 1..15).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, the reset: asynchronous, active-high.
REQ-006 The block SHALL have port rooms, input, 8 bits, the per-room occupancy request (1 = occupied).
REQ-007 The block SHALL have port lightson, output, 8 bits, the per-room light enable (registered).
REQ-008 The block SHALL have port countdown, output, 32 bits, the per-room 4-bit hold timer; room i is bits [4i+3:4i].
REQ-009 The block SHALL have port count, output, 4 bits, the number of lit rooms (popcount of lightson, registered).
REQ-010 The block SHALL have port full, output, 1 bit, asserted when count == MAX_ON.
REQ-011 The block SHALL have port grant_valid, output, 1 bit, a one-cycle pulse when a new room is granted.
REQ-012 The block SHALL have port grant_idx, output, 3 bits, the index of the granted room; valid only with grant_valid.
REQ-013 The block SHALL have port deny_count, output, 8 bits, the denial statistic (see Configuration).

Function
REQ-014 Room i SHALL be lit exactly when countdown[i] != 0; lightson[i] SHALL equal that condition, registered.
REQ-015 For a lit room each cycle: if rooms[i]=1, countdown reloads to HOLD; otherwise countdown decrements by 1.
REQ-016 A lit room SHALL go dark on the cycle its countdown reaches 0, so the light stays on exactly HOLD cycles after the last occupied sample.
REQ-017 A release (countdown 1 -> 0) SHALL free its slot in the same cycle for grant evaluation.
REQ-018 At most one new grant SHALL issue per cycle.
REQ-019 Candidates SHALL be rooms with rooms[i]=1 and countdown[i]=0.
REQ-020 A grant SHALL issue only if (lit count after this cycle's releases) < MAX_ON.
REQ-021 The winner SHALL be the first candidate found scanning circularly from round-robin pointer rr (3 bits) upward.
REQ-022 On a grant: countdown[winner] <= HOLD, rr <= winner+1 mod 8, grant_valid=1 and grant_idx=winner next cycle; with no grant, rr SHALL hold.
REQ-023 The controller FSM SHALL have states IDLE, ACTIVE and FULL.
REQ-024 The FSM SHALL be in IDLE when count==0, ACTIVE when 0<count<MAX_ON, and FULL when count==MAX_ON, each evaluated on the next-state count.
REQ-025 full SHALL equal (state==FULL).
REQ-026 count SHALL never exceed MAX_ON.
REQ-027 Countdowns SHALL never wrap below 0.
REQ-028 A denied candidate SHALL remain a candidate while it is requesting; no request is latched.

Reset
REQ-029 While rst=1, asynchronously: all countdowns 0, lightson=0, count=0, full=0, grant_valid=0, grant_idx=0, rr=0, state IDLE, deny_count=0.
REQ-030 Reset asserted mid-operation SHALL darken all rooms immediately.
REQ-031 After reset release, the first grant SHALL occur on the first rising edge with rst=0.

Configuration
REQ-032 With macro LIGHT_ARBITER_STATS_EN defined, deny_count SHALL increment, saturating at 255, each cycle in which at least one candidate exists and no grant issues because of the MAX_ON limit.
REQ-033 With LIGHT_ARBITER_STATS_EN undefined, deny_count SHALL be tied to 0 and no counter logic SHALL be generated.

Verification (MAX_ON=4, HOLD=9)
REQ-034 Scenario: from reset, rooms=00010010 -> grant_idx 1 then 4 on consecutive cycles; lightson=00010010, count=2, state ACTIVE.
REQ-035 Scenario: from reset, rooms=11111111 -> grants 0,1,2,3 on four consecutive cycles; count=4, full=1, lightson=00001111; with STATS_EN, deny_count increments every following cycle.
REQ-036 Scenario: continuing from REQ-035, rooms=00000000 -> lights stay on 9 cycles with countdown 9->1, then all dark together; count=0, state IDLE.
REQ-037 Scenario: rr=4 with rooms 0..3 and 4..7 requesting and count=0 -> grant order 4,5,6,7; full=1.
REQ-038 Scenario: full, with room 0 vacant and at countdown=1 and room 5 requesting -> in the same cycle room 0 goes dark and room 5 is granted; count stays 4.
REQ-039 Scenario: rst=1 asserted mid-cycle while 3 rooms are lit -> lightson=0, count=0 before the next clock edge.

Source files
------------

// File: rtl/light_arbiter.sv
// light_arbiter: occupancy-driven room lighting with round-robin grants and a cap on lit rooms.
// Optional denial statistic is built only when LIGHT_ARBITER_STATS_EN is defined.
//
// state  | meaning
// IDLE   | no room lit (count == 0)
// ACTIVE | some rooms lit, below the cap (0 < count < MAX_ON)
// FULL   | cap reached (count == MAX_ON), new candidates are denied
module light_arbiter #(
    parameter int N_ROOMS = 8,
    parameter int MAX_ON  = 4,
    parameter int HOLD    = 9
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_ROOMS-1:0]            rooms,
    output logic [N_ROOMS-1:0]            lightson,
    output logic [4*N_ROOMS-1:0]          countdown,
    output logic [$clog2(N_ROOMS+1)-1:0]  count,
    output logic                          full,
    output logic                          grant_valid,
    output logic [$clog2(N_ROOMS)-1:0]    grant_idx,
    output logic [7:0]                    deny_count
);

    localparam int CW = $clog2(N_ROOMS + 1);
    localparam int IW = $clog2(N_ROOMS);
    localparam int SW = IW + 1;
    localparam logic [CW-1:0] MAX_ON_C = CW'(MAX_ON);
    localparam logic [3:0]    HOLD_C   = 4'(HOLD);
    localparam logic [SW-1:0] N_C      = SW'(N_ROOMS);
    localparam logic [IW-1:0] LAST_C   = IW'(N_ROOMS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [N_ROOMS-1:0][3:0] cd_q, cd_d;
    logic [N_ROOMS-1:0]      lit_q, lit_d;
    logic [CW-1:0]           count_q, count_d, lit_after;
    logic [IW-1:0]           rr_q, rr_d;
    logic [IW-1:0]           grant_idx_q, grant_idx_d;
    logic [IW-1:0]           win, idx;
    logic [SW-1:0]           scan;
    logic                    found, grant, grant_valid_q;

    // Timer update first, so releases (1 -> 0) free their slot before the cap test.
    always_comb begin
        cd_d      = cd_q;
        lit_after = '0;
        for (int i = 0; i < N_ROOMS; i++) begin
            if (cd_q[i] != 4'd0) begin
                cd_d[i] = rooms[i] ? HOLD_C : (cd_q[i] - 4'd1);
            end
            if (cd_d[i] != 4'd0) begin
                lit_after = lit_after + CW'(1);
            end
        end

        found = 1'b0;
        win   = '0;
        scan  = '0;
        idx   = '0;
        for (int k = 0; k < N_ROOMS; k++) begin
            scan = {1'b0, rr_q} + SW'(k);
            if (scan >= N_C) begin
                scan = scan - N_C;
            end
            idx = scan[IW-1:0];
            if (!found && rooms[idx] && (cd_q[idx] == 4'd0)) begin
                found = 1'b1;
                win   = idx;
            end
        end

        grant = found && (lit_after < MAX_ON_C);
        if (grant) begin
            cd_d[win] = HOLD_C;
        end
        count_d = lit_after + CW'(grant);

        rr_d        = rr_q;
        grant_idx_d = grant_idx_q;
        if (grant) begin
            rr_d        = (win == LAST_C) ? '0 : (win + IW'(1));
            grant_idx_d = win;
        end

        for (int i = 0; i < N_ROOMS; i++) begin
            lit_d[i] = (cd_d[i] != 4'd0);
        end
    end

    always_comb begin
        state_d = state_q;
        if (count_d == '0) begin
            state_d = IDLE;
        end else if (count_d >= MAX_ON_C) begin
            state_d = FULL;
        end else begin
            state_d = ACTIVE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cd_q          <= '0;
            lit_q         <= '0;
            count_q       <= '0;
            rr_q          <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cd_q          <= cd_d;
            lit_q         <= lit_d;
            count_q       <= count_d;
            rr_q          <= rr_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant;
        end
    end

    assign lightson    = lit_q;
    assign countdown   = cd_q;
    assign count       = count_q;
    assign full        = (state_q == FULL);
    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;

`ifdef LIGHT_ARBITER_STATS_EN
    logic [7:0] deny_q, deny_d;

    // A candidate that is not granted can only have lost to the cap.
    always_comb begin
        deny_d = deny_q;
        if (found && !grant && (deny_q != 8'hFF)) begin
            deny_d = deny_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deny_q <= 8'd0;
        end else begin
            deny_q <= deny_d;
        end
    end

    assign deny_count = deny_q;
`else
    assign deny_count = 8'd0;
`endif

endmodule

// File: tb/tb_light_arbiter.sv
// Scoreboard bench for light_arbiter: a timer-array reference model predicts each cycle,
// a monitor compares the DUT outputs one clock later.
module tb_light_arbiter;

    localparam int MAX_ON = 4;
    localparam int HOLD   = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rooms;
    logic [7:0]  lightson;
    logic [31:0] countdown;
    logic [3:0]  count;
    logic        full;
    logic        grant_valid;
    logic [2:0]  grant_idx;
    logic [7:0]  deny_count;

    light_arbiter #(.N_ROOMS(8), .MAX_ON(MAX_ON), .HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .rooms(rooms), .lightson(lightson),
        .countdown(countdown), .count(count), .full(full),
        .grant_valid(grant_valid), .grant_idx(grant_idx), .deny_count(deny_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  lo;
        logic [31:0] cd;
        logic [3:0]  cnt;
        logic        full;
        logic        gv;
        logic [7:0]  deny;
    } exp_t;

    exp_t sq[$];
    int   gq[$];

    int n_cmp = 0;
    int n_err = 0;

    // reference state: remaining hold time per room, round-robin start, denial tally
    int t[8];
    int rr;
    int deny;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) t[i] = 0;
        rr   = 0;
        deny = 0;
        sq.delete();
        gq.delete();
    endtask

    task automatic apply(input logic [7:0] r);
        int   nt[8];
        int   lit;
        int   win;
        exp_t e;
        rooms = r;
        lit   = 0;
        for (int i = 0; i < 8; i++) begin
            if (t[i] > 0) nt[i] = r[i] ? HOLD : t[i] - 1;
            else          nt[i] = 0;
            if (nt[i] > 0) lit++;
        end
        win = -1;
        for (int k = 0; k < 8; k++) begin
            if (win < 0 && r[(rr + k) % 8] && t[(rr + k) % 8] == 0) win = (rr + k) % 8;
        end
        e.gv = 1'b0;
        if (win >= 0) begin
            if (lit < MAX_ON) begin
                nt[win] = HOLD;
                lit++;
                rr   = (win + 1) % 8;
                e.gv = 1'b1;
                gq.push_back(win);
            end else if (deny < 255) begin
                deny++;
            end
        end
        t = nt;
        e.lo = '0;
        e.cd = '0;
        for (int i = 0; i < 8; i++) begin
            e.lo[i]       = (t[i] > 0);
            e.cd[4*i +: 4] = 4'(t[i]);
        end
        e.cnt  = 4'(lit);
        e.full = (lit == MAX_ON);
`ifdef LIGHT_ARBITER_STATS_EN
        e.deny = 8'(deny);
`else
        e.deny = 8'd0;
`endif
        sq.push_back(e);
    endtask

    task automatic cyc(input logic [7:0] r);
        @(negedge clk);
        apply(r);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_lightson"}, lightson, 32'd0);
        chk({tag, "_countdown"}, countdown, 32'd0);
        chk({tag, "_count"}, count, 32'd0);
        chk({tag, "_full"}, full, 32'd0);
        chk({tag, "_grant_valid"}, grant_valid, 32'd0);
        chk({tag, "_grant_idx"}, grant_idx, 32'd0);
        chk({tag, "_deny"}, deny_count, 32'd0);
    endtask

    // Asserted between edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        @(negedge clk);
        rooms = 8'h00;
        rst   = 1'b1;
        #1;
        check_reset("midrst");
        model_reset();
        @(posedge clk);
    endtask

    task automatic release_apply(input logic [7:0] r);
        @(negedge clk);
        rst = 1'b0;
        apply(r);
    endtask

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sq.size() > 0) begin
                e = sq.pop_front();
                chk("lightson", lightson, e.lo);
                chk("countdown", countdown, e.cd);
                chk("count", count, e.cnt);
                chk("full", full, e.full);
                chk("grant_valid", grant_valid, e.gv);
                chk("deny_count", deny_count, e.deny);
            end
            if (grant_valid) begin
                if (gq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL grant_unexpected: got idx %0d, expected no grant", grant_idx);
                end else begin
                    chk("grant_idx", grant_idx, gq.pop_front());
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        logic [7:0] r;
        int         len;
        rst   = 1'b1;
        rooms = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("por");

        // two rooms from reset: grants 1 then 4
        release_apply(8'b0001_0010);
        repeat (3) cyc(8'b0001_0010);

        // all rooms: grants 0..3, then capped; then vacate and watch the hold expire
        do_reset();
        release_apply(8'hFF);
        repeat (8) cyc(8'hFF);
        repeat (12) cyc(8'h00);

        // pointer now at 4: grants 4..7
        repeat (6) cyc(8'hFF);
        repeat (12) cyc(8'h00);

        // full, room 0 expiring while room 5 requests: hand-over in one cycle
        do_reset();
        release_apply(8'h0F);
        repeat (4) cyc(8'h0F);
        repeat (8) cyc(8'h0E);
        repeat (4) cyc(8'h2E);

        // three rooms lit, then reset between edges
        do_reset();
        release_apply(8'h07);
        repeat (3) cyc(8'h07);
        do_reset();
        release_apply(8'h00);

        for (int seg = 0; seg < 160; seg++) begin
            case ($urandom_range(0, 4))
                0:       r = 8'($urandom) & 8'($urandom);
                1:       r = 8'($urandom);
                2:       r = 8'h00;
                3:       r = 8'($urandom) | 8'($urandom);
                default: r = 8'(1 << $urandom_range(0, 7));
            endcase
            len = $urandom_range(1, 12);
            if ($urandom_range(0, 39) == 0) begin
                do_reset();
                release_apply(r);
                len--;
            end
            repeat (len) cyc(r);
        end

        repeat (3) @(posedge clk);
        #2;
        chk("sb_status_drained", sq.size(), 32'd0);
        chk("sb_grants_drained", gq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
